dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 194 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: single-port word array serving byte, halfword and
// word loads/stores through a small FSM, with sub-word stores done as read-modify-write.
module dmem_responder #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int unsigned WORD_AW = DM_ADDRESS - 2;
    localparam int unsigned DEPTH   = 1 << WORD_AW;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE_ACK,
        RMW_RD,
        RMW_WR,
        ERR
    } state_e;

    state_e                state_q, state_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_W-1:0]     rmw_word_q, rmw_word_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  busy_q, busy_d;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [WORD_AW-1:0]    mem_idx_c;
    logic                  mem_we_c;
    logic [DATA_W-1:0]     mem_wdata_c;
    logic [DATA_W-1:0]     mem_rd_c;
    logic                  accept_c;

    // Select and extend the addressed byte/halfword of a loaded word.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [2:0]        f3,
                                                      input logic [1:0]        lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{(DATA_W-8){b[7]}}, b};
            3'b001:  return {{(DATA_W-16){h[15]}}, h};
            3'b100:  return {(DATA_W-8)'(0), b};
            3'b101:  return {(DATA_W-16)'(0), h};
            default: return word;
        endcase
    endfunction

    // Merge store data into the addressed lanes, leaving the other lanes untouched.
    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                      input logic [DATA_W-1:0] wdata,
                                                      input logic [2:0]        f3,
                                                      input logic [1:0]        lane);
        logic [DATA_W-1:0] m;
        m = word;
        case (f3)
            3'b000:  m[{lane, 3'b000} +: 8]     = wdata[7:0];
            3'b001:  m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: m = wdata;
        endcase
        return m;
    endfunction

    // Illegal funct3 for the direction, or a misaligned halfword/word access.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] lane);
        logic illegal;
        logic misaligned;
        if (we) illegal = !(f3 inside {3'b000, 3'b001, 3'b010});
        else    illegal = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = ((f3[1:0] == 2'b01) && lane[0]) ||
                     ((f3[1:0] == 2'b10) && (lane != 2'b00));
        return illegal || misaligned;
    endfunction

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept_c  = req_valid && req_ready;
    assign mem_rd_c  = mem_q[mem_idx_c];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        rmw_word_d  = rmw_word_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        mem_we_c    = 1'b0;
        mem_idx_c   = addr_q[DM_ADDRESS-1:2];
        mem_wdata_c = store_merge(rmw_word_q, wdata_q, funct3_q, addr_q[1:0]);

        unique case (state_q)
            IDLE: begin
                mem_idx_c = req_addr[DM_ADDRESS-1:2];
                if (accept_c) begin
                    addr_d   = req_addr;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    if (req_bad(req_we, req_funct3, req_addr[1:0])) begin
                        state_d     = ERR;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (!req_we) begin
                        state_d     = LOAD;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = load_extend(mem_rd_c, req_funct3, req_addr[1:0]);
                    end else if (req_funct3 == 3'b010) begin
                        state_d     = STORE_ACK;
                        mem_we_c    = 1'b1;
                        mem_wdata_c = req_wdata;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD, STORE_ACK, ERR: state_d = IDLE;
            RMW_RD: begin
                rmw_word_d  = mem_rd_c;
                state_d     = RMW_WR;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
            end
            RMW_WR: begin
                mem_we_c = we_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Request capture and RMW holding word carry no reset; they are only read after being loaded.
    always_ff @(posedge clk) begin
        addr_q     <= addr_d;
        we_q       <= we_d;
        wdata_q    <= wdata_d;
        funct3_q   <= funct3_d;
        rmw_word_q <= rmw_word_d;
    end

    // Array contents survive reset; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (mem_we_c && !reset) begin
            mem_q[mem_idx_c] <= mem_wdata_c;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: store/load round trips, extension, errors,
// reset during read-modify-write and back-to-back request streams.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_funct3(req_funct3),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Issue one request from an IDLE cycle (posedge+1) and wait a bounded time for its response.
    task automatic do_req(input logic we, input logic [8:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, output logic [31:0] rd, output logic err,
                          output int lat);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_funct3 = f3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = rsp_rdata;
        err = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({rsp_valid, rsp_err, busy, req_ready} !== 4'b0000 || rsp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b err=%b busy=%b ready=%b rdata=%h, want all 0",
                     rsp_valid, rsp_err, busy, req_ready, rsp_rdata);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_rise: got req_ready=%b, want 1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sw_lw();
        logic [31:0] rd; logic err; int lat;
        do_req(1'b1, 9'h010, 32'h8badf00d, 3'b010, rd, err, lat);
        tests_run++;
        if (lat !== 1 || err !== 1'b0 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL sw_ack: got lat=%0d err=%b rdata=%h, want lat=1 err=0 rdata=0", lat, err, rd);
        end
        do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, err, lat);
        tests_run++;
        if (lat !== 1 || err !== 1'b0 || rd !== 32'h8badf00d) begin
            tests_failed++;
            $display("FAIL lw_after_sw: got lat=%0d err=%b rdata=%h, want lat=1 err=0 rdata=8badf00d",
                     lat, err, rd);
        end
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h8badf00d) begin
            tests_failed++;
            $display("FAIL rdata_hold: got valid=%b rdata=%h, want valid=0 rdata=8badf00d",
                     rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_sb();
        logic [31:0] rd; logic err; int lat;
        logic [2:0] trace [3];
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h011; req_wdata = 32'h000000a5;
        req_funct3 = 3'b000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            trace[i] = {busy, rsp_valid, rsp_err};
            @(posedge clk); #1;
        end
        tests_run++;
        if (trace[0] !== 3'b100 || trace[1] !== 3'b110 || trace[2] !== 3'b000) begin
            tests_failed++;
            $display("FAIL sb_timing: got {busy,valid,err}=%b,%b,%b, want 100,110,000",
                     trace[0], trace[1], trace[2]);
        end
        do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, err, lat);
        tests_run++;
        if (lat !== 1 || err !== 1'b0 || rd !== 32'h8bada50d) begin
            tests_failed++;
            $display("FAIL lw_after_sb: got lat=%0d err=%b rdata=%h, want lat=1 err=0 rdata=8bada50d",
                     lat, err, rd);
        end
    endtask

    task automatic test_sh_sb_lanes();
        logic [31:0] rd; logic err; int lat;
        do_req(1'b1, 9'h020, 32'h11223344, 3'b010, rd, err, lat);
        do_req(1'b1, 9'h022, 32'hffffbeef, 3'b001, rd, err, lat);
        tests_run++;
        if (lat !== 2 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL sh_ack: got lat=%0d err=%b, want lat=2 err=0", lat, err);
        end
        do_req(1'b1, 9'h023, 32'h00000077, 3'b000, rd, err, lat);
        do_req(1'b0, 9'h020, 32'h0, 3'b010, rd, err, lat);
        tests_run++;
        if (rd !== 32'h77ef3344 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL sh_sb_merge: got rdata=%h err=%b, want rdata=77ef3344 err=0", rd, err);
        end
    endtask

    task automatic test_extension();
        logic [8:0]  a  [5] = '{9'h013, 9'h013, 9'h012, 9'h012, 9'h010};
        logic [2:0]  f  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] ex [5] = '{32'hffffff8b, 32'h0000008b, 32'hffff8bad, 32'h00008bad, 32'h0000000d};
        logic [31:0] rd; logic err; int lat;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, a[i], 32'h0, f[i], rd, err, lat);
            tests_run++;
            if (rd !== ex[i] || err !== 1'b0 || lat !== 1) begin
                tests_failed++;
                $display("FAIL load_ext[%0d]: addr=%h f3=%b got rdata=%h err=%b lat=%0d, want rdata=%h err=0 lat=1",
                         i, a[i], f[i], rd, err, lat, ex[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic        w [3] = '{1'b0, 1'b1, 1'b0};
        logic [8:0]  a [3] = '{9'h012, 9'h011, 9'h010};
        logic [2:0]  f [3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] rd; logic err; int lat;
        for (int i = 0; i < 3; i++) begin
            do_req(w[i], a[i], 32'hdeadbeef, f[i], rd, err, lat);
            tests_run++;
            if (err !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
                tests_failed++;
                $display("FAIL err_resp[%0d]: got err=%b rdata=%h lat=%0d, want err=1 rdata=0 lat=1",
                         i, err, rd, lat);
            end
        end
        do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, err, lat);
        tests_run++;
        if (rd !== 32'h8bada50d || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_no_write: got rdata=%h err=%b, want rdata=8bada50d err=0", rd, err);
        end
    endtask

    task automatic test_reset_in_rmw();
        logic [31:0] rd; logic err; int lat;
        int seen = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h010; req_wdata = 32'h0000beef;
        req_funct3 = 3'b001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        if (rsp_valid) seen++;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (seen !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmw_reset_no_rsp: got %0d rsp_valid cycles busy=%b, want 0 and busy=0", seen, busy);
        end
        do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, err, lat);
        tests_run++;
        if (rd !== 32'h8bada50d || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmw_reset_no_write: got rdata=%h err=%b, want rdata=8bada50d err=0", rd, err);
        end
    endtask

    task automatic test_back_to_back();
        logic        w [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [8:0]  a [5] = '{9'h010, 9'h020, 9'h024, 9'h024, 9'h020};
        logic [31:0] d [5] = '{32'h0, 32'h0000005a, 32'hcafef00d, 32'h0, 32'h0};
        logic [2:0]  f [5] = '{3'b010, 3'b000, 3'b010, 3'b010, 3'b000};
        logic [31:0] ex [5] = '{32'h8bada50d, 32'h0, 32'h0, 32'hcafef00d, 32'h0000005a};
        logic [31:0] log_rd [8];
        int idx = 0, acc = 0, rsp_cnt = 0, errs = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (rsp_valid) begin
                if (rsp_cnt < 8) log_rd[rsp_cnt] = rsp_rdata;
                if (rsp_err) errs++;
                rsp_cnt++;
            end
            if (idx < 5) begin
                req_valid = 1'b1; req_we = w[idx]; req_addr = a[idx];
                req_wdata = d[idx]; req_funct3 = f[idx];
                if (req_ready) begin
                    acc++;
                    idx++;
                end
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (acc !== 5 || rsp_cnt !== 5 || errs !== 0) begin
            tests_failed++;
            $display("FAIL b2b_counts: got accepts=%0d responses=%0d errors=%0d, want 5 5 0",
                     acc, rsp_cnt, errs);
        end
        for (int i = 0; i < 5; i++) begin
            if (i < rsp_cnt) begin
                tests_run++;
                if (log_rd[i] !== ex[i]) begin
                    tests_failed++;
                    $display("FAIL b2b_rdata[%0d]: got %h, want %h", i, log_rd[i], ex[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_sb();
        test_sh_sb_lanes();
        test_extension();
        test_errors();
        test_reset_in_rmw();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
